// File: rtl/sram_pkg.sv
// Shared types and constants for the external asynchronous SRAM controller.
package sram_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_ALL  = 4'b1111;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD       = 3'd1;
  localparam state_t ST_WR_SETUP = 3'd2;
  localparam state_t ST_WR_PULSE = 3'd3;
  localparam state_t ST_WR_HOLD  = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } ram_ctrl_t;

  localparam ram_ctrl_t RAM_CTRL_IDLE = 3'b111;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable up-counter for access wait timing; done_o flags that the count
// has reached the programmed limit.
module sram_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == limit_i);

  // Loading 1 means the first cycle of the timed state already counts.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(1);
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-word request to timed external asynchronous SRAM access.
// Define SRAM_LAST_READ_EN to short-circuit repeat reads of the last read address.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_sel,
  input  logic [31:0]       req_data,
  output logic [31:0]       rsp_data,
  output logic              rsp_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [31:0]       ram_data,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int CNT_W = cnt_width(READ_WAIT, WRITE_WAIT);
  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(WRITE_WAIT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          sel_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                latch, capture, cnt_load, cnt_en, cnt_done, hit;
  logic [CNT_W-1:0]    cnt_limit;
  ram_ctrl_t           ctrl;
  logic [3:0]          be_n;
  logic                bus_oe;

  sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cnt_load),
    .en_i    (cnt_en),
    .limit_i (cnt_limit),
    .done_o  (cnt_done)
  );

  assign cnt_limit = (state_q == ST_RD) ? RD_LIM : WR_LIM;

`ifdef SRAM_LAST_READ_EN
  logic [ADDR_W-1:0] tag_addr_q;
  logic              tag_vld_q;

  assign hit = tag_vld_q && (tag_addr_q == req_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_addr_q <= '0;
      tag_vld_q  <= 1'b0;
    end else if (capture) begin
      tag_addr_q <= addr_q;
      tag_vld_q  <= 1'b1;
    end else if (latch && req_we && req_sel != SEL_NONE && req_addr == tag_addr_q) begin
      tag_vld_q  <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_ce) begin
          latch = 1'b1;
          if (!req_we) begin
            if (hit) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_RD;
              cnt_load = 1'b1;
            end
          end else if (req_sel == SEL_NONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_SETUP;
          end
        end
      end
      ST_RD: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR_SETUP: begin
        cnt_load = 1'b1;
        state_d  = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        cnt_en = 1'b1;
        if (cnt_done) state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sel_q   <= SEL_NONE;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= req_addr;
        sel_q   <= req_sel;
        wdata_q <= req_data;
      end
      if (capture) rdata_q <= ram_data;
    end
  end

  // Controls decode straight from state so reset forces them inactive at once.
  always_comb begin
    ctrl   = RAM_CTRL_IDLE;
    be_n   = SEL_ALL;
    bus_oe = 1'b0;
    case (state_q)
      ST_RD: begin
        ctrl = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
        be_n = SEL_NONE;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ctrl   = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
        be_n   = ~sel_q;
        bus_oe = 1'b1;
      end
      ST_WR_PULSE: begin
        ctrl   = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
        be_n   = ~sel_q;
        bus_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_data  = bus_oe ? wdata_q : 'z;
  assign ram_addr  = addr_q;
  assign ram_be_n  = be_n;
  assign ram_ce_n  = ctrl.ce_n;
  assign ram_oe_n  = ctrl.oe_n;
  assign ram_we_n  = ctrl.we_n;
  assign rsp_data  = rdata_q;
  assign rsp_ready = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl with a behavioural async SRAM and a read-data scoreboard.
module tb_sram_ctrl;

  localparam int ADDR_W = 10;
  localparam int RW     = 2;
  localparam int WW     = 2;
  localparam int RD_LAT = RW + 1;
  localparam int WR_LAT = WW + 3;

  logic              clk, rst;
  logic              req_ce, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_sel;
  logic [31:0]       req_data;
  logic [31:0]       rsp_data;
  logic              rsp_ready, busy;
  logic [ADDR_W-1:0] ram_addr;
  wire  [31:0]       ram_data;
  logic [3:0]        ram_be_n;
  logic              ram_ce_n, ram_oe_n, ram_we_n;

  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  logic [31:0] exp_mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  sram_ctrl #(.ADDR_W(ADDR_W), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr),
    .req_sel(req_sel), .req_data(req_data), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data), .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr] : 32'bz;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n)
      for (int i = 0; i < 4; i++)
        if (!ram_be_n[i]) mem[ram_addr][8*i +: 8] <= ram_data[8*i +: 8];
  end

  always @(negedge clk) begin
    if (dut.bus_oe && !ram_oe_n) begin
      n_cmp++; n_mis++;
      $display("FAIL bus_contention: controller drives bus while oe_n=%b", ram_oe_n);
    end
  end

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input int exp_lat, input string name,
                        output logic [63:0] we_mask, output logic [63:0] oe_mask,
                        output logic [3:0] be_seen);
    int cyc, guard;
    logic seen;
    logic [31:0] exp_d;
    req_ce = 1'b1; req_we = we; req_addr = addr; req_sel = sel; req_data = data;
    guard = 0;
    while (busy && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!we) exp_q.push_back(exp_mem[addr]);
    else for (int i = 0; i < 4; i++) if (sel[i]) exp_mem[addr][8*i +: 8] = data[8*i +: 8];
    cyc = 0; seen = 1'b0; we_mask = '0; oe_mask = '0; be_seen = 4'b1111;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (!ram_we_n) begin we_mask[cyc] = 1'b1; be_seen = ram_be_n; end
      if (!ram_oe_n) oe_mask[cyc] = 1'b1;
      if (rsp_ready) seen = 1'b1;
    end
    req_ce = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL %s_timeout: no rsp_ready within %0d cycles", name, cyc);
      if (!we) void'(exp_q.pop_front());
    end else begin
      if (cyc != exp_lat) begin
        n_mis++;
        $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat);
      end
      if (!we) begin
        exp_d = exp_q.pop_front();
        n_cmp++;
        if (rsp_data !== exp_d) begin
          n_mis++;
          $display("FAIL %s_rdata: got %h expected %h", name, rsp_data, exp_d);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, busy, rsp_ready, dut.bus_oe} !== 10'b111_1111_000) begin
      n_mis++;
      $display("FAIL %s_idle: ce/oe/we=%b%b%b be_n=%b busy=%b rdy=%b drive=%b expected 111 1111 0 0 0",
               name, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, busy, rsp_ready, dut.bus_oe);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    n_cmp++;
    if (rsp_data !== 32'h0 || ram_addr !== '0) begin
      n_mis++;
      $display("FAIL reset_regs: rsp_data=%h ram_addr=%h expected 0 0", rsp_data, ram_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");
  endtask

  task automatic test_write_read();
    logic [63:0] wm, om; logic [3:0] be;
    do_req(1'b1, 10'h005, 4'b1111, 32'hDEADBEEF, WR_LAT, "full_write", wm, om, be);
    n_cmp++;
    if (wm !== 64'b1100) begin
      n_mis++;
      $display("FAIL full_write_we_cycles: got %h expected %h", wm, 64'b1100);
    end
    do_req(1'b0, 10'h005, 4'b0000, 32'h0, RD_LAT, "read_full", wm, om, be);
    n_cmp++;
    if (om !== 64'b0110 || wm !== 64'h0) begin
      n_mis++;
      $display("FAIL read_oe_cycles: oe=%h we=%h expected 6 0", om, wm);
    end
  endtask

  task automatic test_byte_write();
    logic [63:0] wm, om; logic [3:0] be;
    do_req(1'b1, 10'h005, 4'b0010, 32'h11111111, WR_LAT, "byte_write", wm, om, be);
    n_cmp++;
    if (be !== 4'b1101) begin
      n_mis++;
      $display("FAIL byte_write_be_n: got %b expected 1101", be);
    end
    n_cmp++;
    if (rsp_data !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL rsp_data_hold: got %h expected deadbeef", rsp_data);
    end
    do_req(1'b0, 10'h005, 4'b0000, 32'h0, RD_LAT, "read_byte", wm, om, be);
    n_cmp++;
    if (rsp_data !== 32'hDEAD11EF) begin
      n_mis++;
      $display("FAIL byte_merge: got %h expected dead11ef", rsp_data);
    end
  endtask

  task automatic test_empty_write();
    logic [63:0] wm, om; logic [3:0] be;
    do_req(1'b1, 10'h007, 4'b0000, 32'h12345678, 1, "empty_write", wm, om, be);
    n_cmp++;
    if (wm !== 64'h0) begin
      n_mis++;
      $display("FAIL empty_write_we: we_n low mask %h expected 0", wm);
    end
    do_req(1'b0, 10'h007, 4'b0000, 32'h0, RD_LAT, "read_after_empty", wm, om, be);
  endtask

  task automatic test_back_to_back();
    logic [63:0] wm, om; logic [3:0] be;
    do_req(1'b1, 10'h030, 4'b1001, 32'hA1B2C3D4, WR_LAT, "b2b_write", wm, om, be);
    do_req(1'b0, 10'h030, 4'b0000, 32'h0, RD_LAT, "b2b_read0", wm, om, be);
    do_req(1'b0, 10'h005, 4'b0000, 32'h0, RD_LAT, "b2b_read1", wm, om, be);
    do_req(1'b1, 10'h031, 4'b0100, 32'h55555555, WR_LAT, "b2b_write2", wm, om, be);
    do_req(1'b0, 10'h031, 4'b0000, 32'h0, RD_LAT, "b2b_read2", wm, om, be);
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] wm, om; logic [3:0] be;
    int guard;
    req_ce = 1'b1; req_we = 1'b1; req_addr = 10'h020; req_sel = 4'b1111; req_data = 32'hCAFEF00D;
    guard = 0;
    while (busy && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (ram_we_n !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_write_pulse: we_n=%b expected 0", ram_we_n);
    end
    rst = 1'b1; req_ce = 1'b0;
    #1;
    check_idle_outputs("reset_mid_write");
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (rsp_data !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
    end
    do_req(1'b0, 10'h020, 4'b0000, 32'h0, RD_LAT, "read_after_rst", wm, om, be);
    do_req(1'b0, 10'h005, 4'b0000, 32'h0, RD_LAT, "read5_after_rst", wm, om, be);
  endtask

  task automatic test_last_read();
    logic [63:0] wm, om; logic [3:0] be;
    do_req(1'b0, 10'h010, 4'b0000, 32'h0, RD_LAT, "lr_first", wm, om, be);
`ifdef SRAM_LAST_READ_EN
    do_req(1'b0, 10'h010, 4'b0000, 32'h0, 1, "lr_hit", wm, om, be);
    n_cmp++;
    if (om !== 64'h0) begin
      n_mis++;
      $display("FAIL lr_hit_oe: oe_n low mask %h expected 0", om);
    end
    do_req(1'b1, 10'h010, 4'b1111, 32'h0BADF00D, WR_LAT, "lr_write", wm, om, be);
    do_req(1'b0, 10'h010, 4'b0000, 32'h0, RD_LAT, "lr_after_write", wm, om, be);
    n_cmp++;
    if (om !== 64'b0110) begin
      n_mis++;
      $display("FAIL lr_after_write_oe: got %h expected 6", om);
    end
`else
    do_req(1'b0, 10'h010, 4'b0000, 32'h0, RD_LAT, "lr_repeat", wm, om, be);
    n_cmp++;
    if (om !== 64'b0110) begin
      n_mis++;
      $display("FAIL lr_repeat_oe: got %h expected 6", om);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = 32'hA500_0000 | i;
      exp_mem[i] = 32'hA500_0000 | i;
    end
    rst = 1'b1; req_ce = 1'b0; req_we = 1'b0; req_addr = '0; req_sel = '0; req_data = '0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_empty_write();
    test_back_to_back();
    test_reset_mid_write();
    test_last_read();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
